one_bit_lookahead_carry_calc: RTL and testbench



---
 rtl/lookahead_pkg.sv | 18 +
 rtl/pg_generator.sv | 17 +
 rtl/one_bit_lookahead_carry_calc.sv | 67 ++++++
 tb/tb_one_bit_lookahead_carry_calc.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lookahead_pkg.sv
// Shared types and helpers for the one-bit lookahead carry cell.
package lookahead_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    localparam pg_t PG_RESET = '{p: 1'b0, g: 1'b0};

    function automatic pg_t pg_of(input logic a, input logic b);
        pg_t r;
        r.p = a ^ b;
        r.g = a & b;
        return r;
    endfunction

endpackage

// File: rtl/pg_generator.sv
// Combinational propagate/generate for one bit position.
module pg_generator
    import lookahead_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic p,
    output logic g
);

    pg_t pg;

    assign pg = pg_of(a, b);
    assign p  = pg.p;
    assign g  = pg.g;

endmodule

// File: rtl/one_bit_lookahead_carry_calc.sv
// One-bit carry-lookahead cell with a registered valid/ready output stage.
// ONE_BIT_LOOKAHEAD_CARRY_CALC_APPROX_EN adds approx_mode (carry = generate).
module one_bit_lookahead_carry_calc
    import lookahead_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C0,
    input  logic in_valid,
    output logic in_ready,
`ifdef ONE_BIT_LOOKAHEAD_CARRY_CALC_APPROX_EN
    input  logic approx_mode,
`endif
    output logic C,
    output logic P,
    output logic G,
    output logic out_valid,
    input  logic out_ready
);

    logic p_d;
    logic g_d;
    logic c_d;
    logic accept;
    logic c_q;
    pg_t  pg_q;
    logic valid_q;

    pg_generator u_pg (
        .a(A),
        .b(B),
        .p(p_d),
        .g(g_d)
    );

`ifdef ONE_BIT_LOOKAHEAD_CARRY_CALC_APPROX_EN
    // Approximate mode cuts the ripple: carry-in is ignored.
    assign c_d = approx_mode ? g_d : (g_d | (p_d & C0));
`else
    assign c_d = g_d | (p_d & C0);
`endif

    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= 1'b0;
            pg_q    <= PG_RESET;
            valid_q <= 1'b0;
        end else if (accept) begin
            c_q     <= c_d;
            pg_q    <= '{p: p_d, g: g_d};
            valid_q <= 1'b1;
        end else if (valid_q & out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign C         = c_q;
    assign P         = pg_q.p;
    assign G         = pg_q.g;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_one_bit_lookahead_carry_calc.sv
// Directed self-checking bench for one_bit_lookahead_carry_calc.
module tb_one_bit_lookahead_carry_calc;

    logic clk = 1'b0;
    logic rst;
    logic A;
    logic B;
    logic C0;
    logic in_valid;
    logic in_ready;
    logic C;
    logic P;
    logic G;
    logic out_valid;
    logic out_ready;
`ifdef ONE_BIT_LOOKAHEAD_CARRY_CALC_APPROX_EN
    logic approx_mode = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {C,P,G} indexed by {A,B,C0}
    logic [2:0] exp_tbl [8] = '{3'b000, 3'b000, 3'b010, 3'b110,
                                3'b010, 3'b110, 3'b101, 3'b101};

    one_bit_lookahead_carry_calc dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .B(B),
        .C0(C0),
        .in_valid(in_valid),
        .in_ready(in_ready),
`ifdef ONE_BIT_LOOKAHEAD_CARRY_CALC_APPROX_EN
        .approx_mode(approx_mode),
`endif
        .C(C),
        .P(P),
        .G(G),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b, input logic c0,
                         input logic v, input logic rdy);
        A         = a;
        B         = b;
        C0        = c0;
        in_valid  = v;
        out_ready = rdy;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("reset_cpgv", {C, P, G, out_valid}, 4'b0000);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_in_ready", {3'b0, in_ready}, 4'b0001);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("generate", {C, P, G, out_valid}, 4'b1011);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("prop_no_cin", {C, P, G, out_valid}, 4'b0101);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("prop_cin", {C, P, G, out_valid}, 4'b1101);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(v[2], v[1], v[0], 1'b1, 1'b1);
            tick();
            check($sformatf("exh_%0d", i), {C, P, G, out_valid},
                  {exp_tbl[i], 1'b1});
        end

        // Pending 111 -> {C,P,G}=101; stall with changing inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'(i), 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            check($sformatf("stall_hold_%0d", i), {C, P, G, out_valid}, 4'b1011);
            check($sformatf("stall_rdy_%0d", i), {3'b0, in_ready}, 4'b0000);
        end

        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("replace_rdy", {3'b0, in_ready}, 4'b0001);
        tick();
        check("replace", {C, P, G, out_valid}, 4'b0101);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("drain", {C, P, G, out_valid}, 4'b0100);
        tick();
        check("idle_hold", {C, P, G, out_valid}, 4'b0100);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("load_pending", {C, P, G, out_valid}, 4'b1011);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("reset_prio", {C, P, G, out_valid}, 4'b0000);
        rst = 1'b0;
        check("post_reset_rdy", {3'b0, in_ready}, 4'b0001);

`ifdef ONE_BIT_LOOKAHEAD_CARRY_CALC_APPROX_EN
        approx_mode = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("approx_on", {C, P, G, out_valid}, 4'b0101);
        approx_mode = 1'b0;
        tick();
        check("approx_off", {C, P, G, out_valid}, 4'b1101);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
